// File: rtl/aux_dig_if_pkg.sv
// aux_dig_if_pkg: shared state encoding, default settle times and control bundle for the aux ADC sequencer
package aux_dig_if_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, QUIESCE = 2'd1, PWR = 2'd2, CFG = 2'd3} state_t;
  localparam int PWRUP_CYCLES_DEF = 64;
  localparam int CFG_CYCLES_DEF = 8;
  localparam int CNT_W_DEF = 8;
  typedef struct packed {
    logic       adc_en;
    logic       ch1_en;
    logic       ch1_short;
    logic [1:0] ch1_cal;
    logic       ch2_en;
    logic       ch2_short;
    logic [1:0] ch2_cal;
    logic       iqmux_en;
  } ctrl_t;
endpackage

// File: rtl/aux_wait_cnt.sv
// aux_wait_cnt: loadable down-counter with zero flag for settle waits
module aux_wait_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic             dec,
  input  logic [CNT_W-1:0] val,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (ld) cnt <= val;
    else if (dec) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/aux_adc_ctrl_seq.sv
// aux_adc_ctrl_seq: applies captured mmap ADC settings in power-safe order (chEn off, adcEn, cal/short, chEn on)
module aux_adc_ctrl_seq
  import aux_dig_if_pkg::*;
#(
  parameter int PWRUP_CYCLES = PWRUP_CYCLES_DEF,
  parameter int CFG_CYCLES   = CFG_CYCLES_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic       PClkxCI,
  input  logic       PResetxRBI,
  input  logic       master_ld_mmap_muxed,
  input  logic       reg_adcEn,
  input  logic       reg_ch1_chEn,
  input  logic       reg_ch1_short,
  input  logic [1:0] reg_ch1_calMode,
  input  logic       reg_ch2_chEn,
  input  logic       reg_ch2_short,
  input  logic [1:0] reg_ch2_calMode,
  input  logic       reg_iqmuxEn,
  output logic       CHI_adcEn_muxed,
  output logic       CHI1_chEn_muxed,
  output logic       CHI1_short_muxed,
  output logic [1:0] CHI1_calMode_muxed,
  output logic       CHI2_chEn_muxed,
  output logic       CHI2_short_muxed,
  output logic [1:0] CHI2_calMode_muxed,
  output logic       adc_iqmuxEn_i_muxed,
  output logic       seq_busy,
  output logic       ld_done,
  output logic       ld_pending
);
  state_t state, state_nx;
  ctrl_t regs, sh, q;
  logic ld_q, ld_edge, start, zero, cnt_ld, cnt_dec;
  logic [CNT_W-1:0] cnt_val;
  assign regs = {reg_adcEn, reg_ch1_chEn, reg_ch1_short, reg_ch1_calMode,
                 reg_ch2_chEn, reg_ch2_short, reg_ch2_calMode, reg_iqmuxEn};
  assign ld_edge = master_ld_mmap_muxed & ~ld_q;
  assign start = state == IDLE && (ld_edge || ld_pending);
  assign seq_busy = state != IDLE;
  always_comb begin
    state_nx = state;
    cnt_ld = 1'b0;
    cnt_dec = 1'b0;
    cnt_val = '0;
    case (state)
      IDLE: state_nx = start ? QUIESCE : IDLE;
      QUIESCE: begin
        state_nx = PWR;
        cnt_ld = 1'b1;
        // the long power-up settle applies only when the ADC is actually being switched on
        cnt_val = (sh.adc_en & ~q.adc_en) ? CNT_W'(PWRUP_CYCLES - 1) : '0;
      end
      PWR: begin
        state_nx = zero ? CFG : PWR;
        cnt_ld = zero;
        cnt_dec = ~zero;
        cnt_val = CNT_W'(CFG_CYCLES - 1);
      end
      CFG: begin
        state_nx = zero ? IDLE : CFG;
        cnt_dec = ~zero;
      end
    endcase
  end
  always_ff @(posedge PClkxCI or negedge PResetxRBI) begin
    if (!PResetxRBI) begin
      state <= IDLE;
      ld_q <= 1'b1;
      ld_pending <= 1'b0;
      ld_done <= 1'b0;
      sh <= '0;
      q <= '0;
    end else begin
      state <= state_nx;
      ld_q <= master_ld_mmap_muxed;
      ld_done <= state == CFG && zero;
      ld_pending <= start ? 1'b0 : ld_pending | (ld_edge && state != IDLE);
      if (start) begin
        sh <= regs;
        q.ch1_en <= 1'b0;
        q.ch2_en <= 1'b0;
        q.iqmux_en <= 1'b0;
      end
      if (state == QUIESCE) q.adc_en <= sh.adc_en;
      if (state == PWR && zero) begin
        q.ch1_cal <= sh.ch1_cal;
        q.ch1_short <= sh.ch1_short;
        q.ch2_cal <= sh.ch2_cal;
        q.ch2_short <= sh.ch2_short;
      end
      if (state == CFG && zero) begin
        q.ch1_en <= sh.ch1_en;
        q.ch2_en <= sh.ch2_en;
        q.iqmux_en <= sh.iqmux_en;
      end
    end
  end
  aux_wait_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk  (PClkxCI),
    .rst_n(PResetxRBI),
    .ld   (cnt_ld),
    .dec  (cnt_dec),
    .val  (cnt_val),
    .zero (zero)
  );
  assign CHI_adcEn_muxed = q.adc_en;
  assign CHI1_chEn_muxed = q.ch1_en;
  assign CHI1_short_muxed = q.ch1_short;
  assign CHI1_calMode_muxed = q.ch1_cal;
  assign CHI2_chEn_muxed = q.ch2_en;
  assign CHI2_short_muxed = q.ch2_short;
  assign CHI2_calMode_muxed = q.ch2_cal;
  assign adc_iqmuxEn_i_muxed = q.iqmux_en;
endmodule

// File: tb/tb_aux_adc_ctrl_seq.sv
// tb_aux_adc_ctrl_seq: directed + random loads against a timeline model of the sequencer
module tb_aux_adc_ctrl_seq;
  localparam int PW = 64;
  localparam int CF = 8;
  // field groups in r/e: {adc, c1en, c1sh, c1cal[1:0], c2en, c2sh, c2cal[1:0], iq}
  localparam logic [9:0] M_ADC = 10'h200;
  localparam logic [9:0] M_EN = 10'h111;
  localparam logic [9:0] M_CS = 10'h0EE;
  logic clk = 1'b0, rst_n = 1'b0, ld = 1'b1;
  logic [9:0] r = '0;
  logic adc, c1en, c1sh, c2en, c2sh, iq, busy, done, pend;
  logic [1:0] c1cal, c2cal;
  int vecs = 0, errs = 0, k = 0, s = 0, n = 0, d = 0;
  bit act = 0;
  logic [9:0] e = '0, snap = '0;
  logic e_busy = 0, e_done = 0, e_pend = 0, prev = 1;
  string tag = "reset";
  always #5 clk = ~clk;
  aux_adc_ctrl_seq dut (
    .PClkxCI(clk), .PResetxRBI(rst_n), .master_ld_mmap_muxed(ld),
    .reg_adcEn(r[9]), .reg_ch1_chEn(r[8]), .reg_ch1_short(r[7]), .reg_ch1_calMode(r[6:5]),
    .reg_ch2_chEn(r[4]), .reg_ch2_short(r[3]), .reg_ch2_calMode(r[2:1]), .reg_iqmuxEn(r[0]),
    .CHI_adcEn_muxed(adc), .CHI1_chEn_muxed(c1en), .CHI1_short_muxed(c1sh),
    .CHI1_calMode_muxed(c1cal), .CHI2_chEn_muxed(c2en), .CHI2_short_muxed(c2sh),
    .CHI2_calMode_muxed(c2cal), .adc_iqmuxEn_i_muxed(iq),
    .seq_busy(busy), .ld_done(done), .ld_pending(pend)
  );
  task automatic model_reset();
    e = '0; snap = '0; e_busy = 0; e_done = 0; e_pend = 0; prev = 1; act = 0;
  endtask
  // one clock edge k: a load started at edge s updates adcEn at s+1, cal/short at s+1+n, enables at d
  task automatic step();
    logic edg, idle;
    edg = ld & ~prev;
    prev = ld;
    e_done = 0;
    idle = !act || k > d;
    if (act && k == s + 1) e = (e & ~M_ADC) | (snap & M_ADC);
    if (act && k == s + 1 + n) e = (e & ~M_CS) | (snap & M_CS);
    if (act && k == d) begin
      e = (e & ~M_EN) | (snap & M_EN);
      e_done = 1;
    end
    if (edg && !idle) e_pend = 1;
    if (idle && (edg || e_pend)) begin
      act = 1; s = k; snap = r; e_pend = 0;
      n = (snap[9] && !e[9]) ? PW : 1;
      d = s + 1 + n + CF;
      e = e & ~M_EN;
    end
    e_busy = act && k >= s && k < d;
    k++;
  endtask
  task automatic check();
    logic [12:0] obs, exp;
    obs = {adc, c1en, c1sh, c1cal, c2en, c2sh, c2cal, iq, busy, done, pend};
    exp = {e, e_busy, e_done, e_pend};
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s edge %0d observed=%b expected=%b", tag, k, obs, exp);
    end
  endtask
  task automatic cyc(int c = 1);
    repeat (c) begin
      @(posedge clk);
      if (rst_n) step();
      @(negedge clk);
      check();
    end
  endtask
  task automatic load();
    ld = 1; cyc(); ld = 0;
  endtask
  initial begin
    r = 10'($urandom);
    model_reset();
    #1 check();
    cyc(3);
    rst_n = 1;
    tag = "release_ld_high";
    cyc(5);
    tag = "first_load";
    ld = 0;
    r = {1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b1};
    cyc();
    load(); cyc(80);
    tag = "reload";
    r = {1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 2'b00, 1'b1};
    load(); cyc(15);
    tag = "pending";
    r[9] = 0;
    load(); cyc(15);
    r[9] = 1;
    load(); cyc(10);
    repeat (3) begin
      load(); cyc(2);
    end
    cyc(160);
    tag = "cal_change";
    r[6:5] = 2'b10;
    load(); cyc(4);
    r[6:5] = 2'b01;
    cyc(15);
    load(); cyc(15);
    tag = "edge_at_done";
    load(); cyc(9);
    load(); cyc(25);
    tag = "reset_mid";
    r[9] = 0;
    load(); cyc(15);
    r[9] = 1;
    load(); cyc(30);
    rst_n = 0;
    model_reset();
    #1 check();
    cyc(3);
    rst_n = 1;
    tag = "after_reset";
    r = 10'($urandom) | M_ADC;
    load(); cyc(80);
    tag = "random";
    repeat (1500) begin
      if ($urandom_range(19) == 0) r = 10'($urandom);
      ld = $urandom_range(29) == 0;
      cyc();
    end
    ld = 0;
    cyc(160);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
